// File: rtl/cgra_obi_master_slice_pkg.sv
// Packages for the CGRA OBI master slice.
// obi_pkg and heepsilon_pkg mirror the codebase packages this slice builds on.
// cgra_obi_master_slice_pkg holds the sizing helpers shared by the channel and the top.

package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

package heepsilon_pkg;

    localparam int unsigned CGRA_XBAR_NMASTER          = 4;
    localparam int unsigned CGRA_SLICE_DEPTH           = 2;
    localparam int unsigned CGRA_SLICE_MAX_OUTSTANDING = 4;

endpackage

package cgra_obi_master_slice_pkg;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int unsigned slice_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Fill level has to represent 0..depth inclusive.
    function automatic int unsigned slice_occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Outstanding counter has to represent 0..max_outstanding inclusive.
    function automatic int unsigned slice_cnt_w(input int unsigned max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/cgra_obi_master_slice_ch.sv
// One channel of the OBI master slice: a small request FIFO that breaks the
// gnt path from the bus, an outstanding-transaction limiter, a pass-through
// response path and a sticky response-underflow flag.
// DEPTH must be a power of two >= 2 and MAX_OUTSTANDING >= DEPTH.

module obi_req_slice_ch
    import obi_pkg::*;
    import cgra_obi_master_slice_pkg::*;
#(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  obi_req_t                        slv_req_i,
    output obi_resp_t                       slv_resp_o,
    output obi_req_t                        mst_req_o,
    input  obi_resp_t                       mst_resp_i,
    output logic [slice_occ_w(DEPTH)-1:0]   occupancy_o,
    output logic                            err_o
);

    localparam int unsigned PTR_W = slice_ptr_w(DEPTH);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = slice_occ_w(DEPTH);
    localparam int unsigned CNT_W = slice_cnt_w(MAX_OUTSTANDING);

    obi_req_t           mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   outstanding_reg;
    logic [CNT_W-1:0]   outstanding_next;
    logic               err_reg;
    logic               gnt_block_reg;

    logic               full;
    logic               empty;
    logic               cap_ok;
    logic               gnt;
    logic               push;
    logic               pop;
    logic               rsp_dec;
    logic               underflow;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;

    assign wr_idx = wr_ptr_reg[IDX_W-1:0];
    assign rd_idx = rd_ptr_reg[IDX_W-1:0];

    // Same index with differing wrap bits means the FIFO has lapped the reader.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) && (wr_idx == rd_idx);

    // Every term is registered (or a master input), so there is no path from mst_resp_i to gnt.
    // gnt is also held off in the reset cycle and the cycle right after it.
    assign cap_ok = (outstanding_reg < CNT_W'(MAX_OUTSTANDING));
    assign gnt    = slv_req_i.req && !full && cap_ok && !rst_i && !gnt_block_reg;
    assign push   = gnt;
    assign pop    = mst_req_o.req && mst_resp_i.gnt;

    // A response with nothing outstanding is a stray one (e.g. its request was dropped by reset).
    assign underflow = mst_resp_i.rvalid && (outstanding_reg == '0);
    assign rsp_dec   = mst_resp_i.rvalid && !underflow;

    assign occupancy_o = OCC_W'(wr_ptr_reg - rd_ptr_reg);
    assign err_o       = err_reg;

    // Upstream response: registered gnt terms, responses forwarded unregistered.
    always_comb begin
        slv_resp_o        = '0;
        slv_resp_o.gnt    = gnt;
        slv_resp_o.rvalid = mst_resp_i.rvalid;
        slv_resp_o.rdata  = mst_resp_i.rdata;
    end

    // Downstream request straight from the FIFO head; the head only moves on a handshake, so fields hold while stalled.
    always_comb begin
        mst_req_o = '0;
        if (!empty && !rst_i) begin
            mst_req_o     = mem_reg[rd_idx];
            mst_req_o.req = 1'b1;
        end
    end

    // Outstanding count: push adds one, a matched response removes one, both together cancel.
    always_comb begin
        outstanding_next = outstanding_reg;
        case ({push, rsp_dec})
            2'b10:   outstanding_next = outstanding_reg + CNT_W'(1);
            2'b01:   outstanding_next = outstanding_reg - CNT_W'(1);
            default: outstanding_next = outstanding_reg;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers decide validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_reg[wr_idx] <= slv_req_i;
        end
    end

    // Pointers, outstanding counter, sticky error and the post-reset grant block.
    always_ff @(posedge clk_i) begin
        gnt_block_reg <= rst_i;
        if (rst_i) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            outstanding_reg <= '0;
            err_reg         <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            outstanding_reg <= outstanding_next;
            if (underflow) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cgra_obi_master_slice.sv
// Registered OBI request slice between the CGRA master ports and the external
// bus master inputs: one fully independent channel per CGRA master.

module cgra_obi_master_slice
    import obi_pkg::*;
    import cgra_obi_master_slice_pkg::*;
#(
    parameter int unsigned NMASTER         = heepsilon_pkg::CGRA_XBAR_NMASTER,
    parameter int unsigned DEPTH           = heepsilon_pkg::CGRA_SLICE_DEPTH,
    parameter int unsigned MAX_OUTSTANDING = heepsilon_pkg::CGRA_SLICE_MAX_OUTSTANDING
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  obi_req_t  [NMASTER-1:0]                       slv_req_i,
    output obi_resp_t [NMASTER-1:0]                       slv_resp_o,
    output obi_req_t  [NMASTER-1:0]                       mst_req_o,
    input  obi_resp_t [NMASTER-1:0]                       mst_resp_i,
    output logic      [NMASTER-1:0][slice_occ_w(DEPTH)-1:0] occupancy_o,
    output logic      [NMASTER-1:0]                       err_o
);

    genvar gi;

    // One channel per master; channels share nothing.
    generate
        for (gi = 0; gi < int'(NMASTER); gi++) begin : g_ch
            obi_req_slice_ch #(
                .DEPTH           (DEPTH),
                .MAX_OUTSTANDING (MAX_OUTSTANDING)
            ) u_ch (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .slv_req_i   (slv_req_i[gi]),
                .slv_resp_o  (slv_resp_o[gi]),
                .mst_req_o   (mst_req_o[gi]),
                .mst_resp_i  (mst_resp_i[gi]),
                .occupancy_o (occupancy_o[gi]),
                .err_o       (err_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_cgra_obi_master_slice.sv
// Directed bench for cgra_obi_master_slice: reset, single write, back-pressure,
// outstanding cap, streaming and reset with a stray response.

module tb_cgra_obi_master_slice;
    import obi_pkg::*;

    localparam int NM    = heepsilon_pkg::CGRA_XBAR_NMASTER;
    localparam int DEPTH = 2;
    localparam int MAXO  = 4;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                          clk = 1'b0;
    logic                          rst;
    obi_req_t  [NM-1:0]            slv_req;
    obi_resp_t [NM-1:0]            slv_resp;
    obi_req_t  [NM-1:0]            mst_req;
    obi_resp_t [NM-1:0]            mst_resp;
    logic      [NM-1:0][OCC_W-1:0] occ;
    logic      [NM-1:0]            err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cgra_obi_master_slice #(
        .NMASTER         (NM),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .slv_req_i   (slv_req),
        .slv_resp_o  (slv_resp),
        .mst_req_o   (mst_req),
        .mst_resp_i  (mst_resp),
        .occupancy_o (occ),
        .err_o       (err)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic obi_req_t rd_req(input logic [31:0] a);
        obi_req_t r;
        r       = '0;
        r.req   = 1'b1;
        r.be    = 4'hF;
        r.addr  = a;
        return r;
    endfunction

    function automatic logic [31:0] saddr(input int k);
        return 32'h0004_0000 + 32'(k * 4);
    endfunction

    function automatic logic [31:0] sdata(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    logic        resp_v [64];
    logic [31:0] resp_d [64];

    initial begin
        obi_req_t wr;
        int       si;
        int       pop_cnt;
        int       rsp_cnt;

        slv_req  = '0;
        mst_resp = '0;
        rst      = 1'b1;

        // ---------------- 1: reset with a pending request ----------------
        slv_req[0] = rd_req(32'h0000_0100);
        settle();
        check_value("rst_c1_gnt",  64'(slv_resp[0].gnt), 64'd0);
        check_value("rst_c1_mreq", 64'(mst_req[0].req),  64'd0);
        tick();
        settle();
        check_value("rst_c2_gnt",  64'(slv_resp[0].gnt), 64'd0);
        check_value("rst_c2_mreq", 64'(mst_req[0].req),  64'd0);
        tick();
        rst = 1'b0;
        settle();
        check_value("rst_after_gnt",  64'(slv_resp[0].gnt), 64'd0);
        check_value("rst_after_mreq", 64'(mst_req[0].req),  64'd0);
        check_value("rst_after_occ",  64'(occ[0]),          64'd0);
        check_value("rst_after_err",  64'(err),             64'd0);
        tick();
        slv_req[0] = '0;
        tick();

        // ---------------- 2: single write ----------------
        wr       = '0;
        wr.req   = 1'b1;
        wr.we    = 1'b1;
        wr.be    = 4'hF;
        wr.addr  = 32'h0002_0010;
        wr.wdata = 32'hDEAD_BEEF;
        slv_req[0] = wr;
        mst_resp[0].gnt = 1'b1;
        settle();
        check_value("wr_gnt",          64'(slv_resp[0].gnt), 64'd1);
        check_value("wr_no_bypass",    64'(mst_req[0].req),  64'd0);
        tick();
        slv_req[0] = '0;
        settle();
        check_value("wr_mreq",  64'(mst_req[0].req),   64'd1);
        check_value("wr_we",    64'(mst_req[0].we),    64'd1);
        check_value("wr_be",    64'(mst_req[0].be),    64'hF);
        check_value("wr_addr",  64'(mst_req[0].addr),  64'h0002_0010);
        check_value("wr_wdata", 64'(mst_req[0].wdata), 64'hDEAD_BEEF);
        check_value("wr_occ",   64'(occ[0]),           64'd1);
        tick();
        mst_resp[0].gnt    = 1'b0;
        mst_resp[0].rvalid = 1'b1;
        mst_resp[0].rdata  = 32'h0;
        settle();
        check_value("wr_rvalid_fwd", 64'(slv_resp[0].rvalid), 64'd1);
        check_value("wr_mreq_done",  64'(mst_req[0].req),     64'd0);
        check_value("wr_occ_done",   64'(occ[0]),             64'd0);
        tick();
        mst_resp[0] = '0;
        settle();
        check_value("wr_err", 64'(err[0]), 64'd0);
        tick();

        // ---------------- 3: back-pressure ----------------
        slv_req[0] = rd_req(32'h0000_1000);
        settle();
        check_value("bp_r1_gnt", 64'(slv_resp[0].gnt), 64'd1);
        tick();
        slv_req[0] = rd_req(32'h0000_1004);
        settle();
        check_value("bp_r2_gnt",  64'(slv_resp[0].gnt), 64'd1);
        check_value("bp_c2_addr", 64'(mst_req[0].addr), 64'h1000);
        tick();
        slv_req[0] = rd_req(32'h0000_1008);
        settle();
        check_value("bp_r3_gnt",  64'(slv_resp[0].gnt), 64'd0);
        check_value("bp_occ",     64'(occ[0]),          64'd2);
        check_value("bp_c3_addr", 64'(mst_req[0].addr), 64'h1000);
        tick();
        mst_resp[0].gnt = 1'b1;
        settle();
        check_value("bp_c4_gnt",  64'(slv_resp[0].gnt), 64'd0);
        check_value("bp_c4_addr", 64'(mst_req[0].addr), 64'h1000);
        tick();
        settle();
        check_value("bp_r3_gnt_late", 64'(slv_resp[0].gnt), 64'd1);
        check_value("bp_c5_addr",     64'(mst_req[0].addr), 64'h1004);
        tick();
        slv_req[0] = '0;
        settle();
        check_value("bp_c6_addr", 64'(mst_req[0].addr), 64'h1008);
        check_value("bp_c6_occ",  64'(occ[0]),          64'd1);
        tick();
        mst_resp[0].gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mst_resp[0].rvalid = 1'b1;
            mst_resp[0].rdata  = 32'hD000_0000 + 32'(k);
            settle();
            if (k == 0) check_value("bp_drained", 64'(mst_req[0].req), 64'd0);
            check_value("bp_rdata", 64'(slv_resp[0].rdata), 64'(32'hD000_0000 + 32'(k)));
            tick();
        end
        mst_resp[0] = '0;
        tick();

        // ---------------- 4: outstanding cap ----------------
        mst_resp[0].gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            slv_req[0] = rd_req(32'h0000_2000 + 32'(k * 4));
            settle();
            check_value("cap_gnt", 64'(slv_resp[0].gnt), 64'd1);
            if (k == 1) check_value("cap_head_addr", 64'(mst_req[0].addr), 64'h2000);
            tick();
        end
        slv_req[0] = rd_req(32'h0000_2010);
        slv_req[1] = rd_req(32'h0000_3000);
        settle();
        check_value("cap_5th_gnt",   64'(slv_resp[0].gnt), 64'd0);
        check_value("cap_other_gnt", 64'(slv_resp[1].gnt), 64'd1);
        tick();
        slv_req[1] = '0;
        mst_resp[0].rvalid = 1'b1;
        mst_resp[0].rdata  = 32'h0000_2000;
        settle();
        check_value("cap_5th_gnt_rv", 64'(slv_resp[0].gnt), 64'd0);
        check_value("cap_other_mreq", 64'(mst_req[1].req),  64'd1);
        check_value("cap_other_addr", 64'(mst_req[1].addr), 64'h3000);
        tick();
        mst_resp[0].rvalid = 1'b0;
        settle();
        check_value("cap_5th_gnt_after", 64'(slv_resp[0].gnt), 64'd1);
        tick();
        slv_req[0] = '0;
        for (int k = 0; k < 4; k++) begin
            mst_resp[0].rvalid = 1'b1;
            mst_resp[0].rdata  = 32'h0000_2004 + 32'(k * 4);
            tick();
        end
        mst_resp[0] = '0;
        settle();
        check_value("cap_err", 64'(err[0]), 64'd0);
        tick();

        // ---------------- 5: streaming ----------------
        for (int t = 0; t < 64; t++) begin
            resp_v[t] = 1'b0;
            resp_d[t] = '0;
        end
        si      = 0;
        pop_cnt = 0;
        rsp_cnt = 0;
        for (int t = 0; t < 24; t++) begin
            slv_req[0]         = (si < 16) ? rd_req(saddr(si)) : '0;
            mst_resp[0].gnt    = 1'b1;
            mst_resp[0].rvalid = resp_v[t];
            mst_resp[0].rdata  = resp_d[t];
            settle();
            if (si < 16) begin
                check_value("str_gnt", 64'(slv_resp[0].gnt), 64'd1);
                if (slv_resp[0].gnt) si++;
            end
            if (mst_req[0].req) begin
                check_value("str_mst_addr", 64'(mst_req[0].addr), 64'(saddr(pop_cnt)));
                resp_v[t + 2] = 1'b1;
                resp_d[t + 2] = sdata(mst_req[0].addr);
                pop_cnt++;
            end
            if (slv_resp[0].rvalid) begin
                check_value("str_rdata", 64'(slv_resp[0].rdata), 64'(sdata(saddr(rsp_cnt))));
                rsp_cnt++;
            end
            tick();
        end
        mst_resp[0] = '0;
        slv_req[0]  = '0;
        check_value("str_pops", 64'(pop_cnt), 64'd16);
        check_value("str_rsps", 64'(rsp_cnt), 64'd16);
        check_value("str_err",  64'(err[0]),  64'd0);
        tick();

        // ---------------- 6: reset mid-operation, stray response ----------------
        mst_resp[0].gnt = 1'b1;
        slv_req[0] = rd_req(32'h0000_5000);
        tick();
        slv_req[0] = rd_req(32'h0000_5004);
        tick();
        mst_resp[0].gnt = 1'b0;
        slv_req[0] = rd_req(32'h0000_5008);
        tick();
        slv_req[0] = '0;
        settle();
        check_value("mid_occ",  64'(occ[0]),          64'd2);
        check_value("mid_addr", 64'(mst_req[0].addr), 64'h5004);
        tick();
        rst = 1'b1;
        mst_resp[0].gnt = 1'b1;
        settle();
        check_value("mid_rst_mreq", 64'(mst_req[0].req), 64'd0);
        tick();
        rst = 1'b0;
        settle();
        check_value("mid_post_mreq", 64'(mst_req[0].req), 64'd0);
        check_value("mid_post_occ",  64'(occ[0]),         64'd0);
        check_value("mid_post_err",  64'(err[0]),         64'd0);
        tick();
        mst_resp[0].rvalid = 1'b1;
        mst_resp[0].rdata  = 32'h5555_AAAA;
        settle();
        check_value("stray_rvalid", 64'(slv_resp[0].rvalid), 64'd1);
        check_value("stray_rdata",  64'(slv_resp[0].rdata),  64'h5555_AAAA);
        check_value("stray_mreq",   64'(mst_req[0].req),     64'd0);
        tick();
        mst_resp[0] = '0;
        settle();
        check_value("stray_err",    64'(err),            64'd1);
        check_value("stray_mreq2",  64'(mst_req[0].req), 64'd0);
        tick();
        tick();
        settle();
        check_value("stray_err_sticky", 64'(err), 64'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
